// File: rtl/tulul_pkg.sv
// Shared TL-UL package: bus widths, opcodes, channel structs and the vbits() helper.
package tulul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = $clog2($clog2(TL_DBW) + 1);

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_m_op;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_m_op;

    typedef struct packed {
        logic                a_valid;
        tl_a_m_op            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_m_op            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

    // Bits needed to index 'value' entries, never less than one.
    function automatic int unsigned vbits(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/tlul_host_adapter_rsp_tracker.sv
// Per-tag table of in-flight requests and the response opcode each one expects.
// Only instantiated when TLUL_HOST_RSP_CHECK_EN is defined.
module tlul_host_rsp_tracker
    import tulul_pkg::*;
#(
    parameter int unsigned MAX_REQS = 1,
    parameter int unsigned SRC_BASE = 0,
    localparam int unsigned TAG_W   = vbits(MAX_REQS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              grant_i,
    input  logic [TAG_W-1:0]  grant_tag_i,
    input  logic              grant_get_i,
    input  logic              rsp_i,
    input  logic [TL_AIW-1:0] rsp_source_i,
    input  tl_d_m_op          rsp_opcode_i,
    output logic              bad_o
);

    localparam logic [TL_AIW-1:0] LO_MASK  = TL_AIW'((1 << TAG_W) - 1);
    localparam logic [TL_AIW-1:0] SRC_VEC  = TL_AIW'(SRC_BASE);

    logic [MAX_REQS-1:0] vld_q, vld_d;
    logic [MAX_REQS-1:0] exp_data_q, exp_data_d;
    logic [TAG_W-1:0]    rsp_tag;
    logic                base_ok;
    logic                rsp_is_data;

    assign rsp_tag     = rsp_source_i[TAG_W-1:0];
    assign base_ok     = ((rsp_source_i ^ SRC_VEC) & ~LO_MASK) == '0;
    assign rsp_is_data = (rsp_opcode_i == AccessAckData);

    // A tag beyond MAX_REQS never matches any entry, so it falls out as bad.
    always_comb begin
        bad_o = 1'b1;
        for (int i = 0; i < int'(MAX_REQS); i++) begin
            if (base_ok && rsp_tag == TAG_W'(i) && vld_q[i] && exp_data_q[i] == rsp_is_data)
                bad_o = 1'b0;
        end
    end

    always_comb begin
        vld_d      = vld_q;
        exp_data_d = exp_data_q;
        for (int i = 0; i < int'(MAX_REQS); i++) begin
            if (rsp_i && base_ok && rsp_tag == TAG_W'(i))
                vld_d[i] = 1'b0;
            if (grant_i && grant_tag_i == TAG_W'(i)) begin
                vld_d[i]      = 1'b1;
                exp_data_d[i] = grant_get_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q      <= '0;
            exp_data_q <= '0;
        end else begin
            vld_q      <= vld_d;
            exp_data_q <= exp_data_d;
        end
    end

endmodule

// File: rtl/tlul_host_adapter.sv
// TL-UL host adapter: core req/gnt port to TL-UL A channel, D channel back to rvalid/rdata/err.
// Optional response source/opcode checking is enabled with TLUL_HOST_RSP_CHECK_EN.
module tlul_host_adapter
    import tulul_pkg::*;
#(
    parameter int unsigned MAX_REQS = 1,
    parameter int unsigned SRC_BASE = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [TL_AW-1:0]  addr_i,
    input  logic              we_i,
    input  logic [TL_DW-1:0]  wdata_i,
    input  logic [TL_DBW-1:0] be_i,
    output logic              rvalid_o,
    output logic [TL_DW-1:0]  rdata_o,
    output logic              err_o,
    output tl_h2d_t           tl_o,
    input  tl_d2h_t           tl_i
);

    localparam int unsigned TAG_W = vbits(MAX_REQS);
    localparam int unsigned CNT_W = $clog2(MAX_REQS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_REQS);
    localparam logic [TL_AIW-1:0] SRC_VEC = TL_AIW'(SRC_BASE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             a_valid;
    logic             rsp_acc;
    logic             bad_rsp;
    logic             unused_d;

    assign a_valid = req_i & rst_ni & (cnt_q < CNT_MAX);
    assign gnt_o   = a_valid & tl_i.a_ready;
    // Responses with nothing outstanding are drained but never reported.
    assign rsp_acc = rst_ni & tl_i.d_valid & (cnt_q != '0);

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        if (!we_i)
            tl_o.a_opcode = Get;
        else if (&be_i)
            tl_o.a_opcode = PutFullData;
        else
            tl_o.a_opcode = PutPartialData;
        tl_o.a_param   = 3'b000;
        tl_o.a_size    = TL_SZW'($clog2(TL_DBW));
        tl_o.a_source  = SRC_VEC;
        tl_o.a_source[TAG_W-1:0] = tag_q;
        tl_o.a_address = {addr_i[TL_AW-1:2], 2'b00};
        tl_o.a_mask    = we_i ? be_i : '1;
        tl_o.a_data    = we_i ? wdata_i : '0;
        tl_o.d_ready   = 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        tag_d = tag_q;
        case ({gnt_o, rsp_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (gnt_o)
            tag_d = (MAX_REQS == 1) ? '0 : tag_q + TAG_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tag_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tag_q <= tag_d;
        end
    end

`ifdef TLUL_HOST_RSP_CHECK_EN
    tlul_host_rsp_tracker #(
        .MAX_REQS (MAX_REQS),
        .SRC_BASE (SRC_BASE)
    ) u_rsp_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .grant_i      (gnt_o),
        .grant_tag_i  (tag_q),
        .grant_get_i  (!we_i),
        .rsp_i        (rsp_acc),
        .rsp_source_i (tl_i.d_source),
        .rsp_opcode_i (tl_i.d_opcode),
        .bad_o        (bad_rsp)
    );
`else
    assign bad_rsp = 1'b0;
`endif

    assign rvalid_o = rsp_acc;
    assign rdata_o  = (rsp_acc && tl_i.d_opcode == AccessAckData) ? tl_i.d_data : '0;
    assign err_o    = rsp_acc & (tl_i.d_error | bad_rsp);

    assign unused_d = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink};

endmodule
